// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Byte FIFO plus handshake sequencer sitting directly in front of the UART
// transmitter. The host pushes bytes at clk rate. The sequencer presents the
// head byte, pulses Tx_WR, waits for TX_BUSY to rise (commit/pop) and then to
// fall (frame done). If the transmitter never starts, the byte stays queued
// and is presented again on the next LOAD.
//
// Optional build feature: define UART_TXQ_OVF_CNT_EN to add a saturating
// 16-bit ovf_count output counting dropped pushes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | TX_EN low; waiting for a queued byte and tx_enable
// LOAD      | head byte on Tx_DATA, Tx_WR pulsed for this single cycle
// WAIT_BUSY | waiting for TX_BUSY to rise; START_TIMEOUT cycle limit
// WAIT_DONE | byte popped; waiting for TX_BUSY to fall (no limit)

module uart_tx_queue #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int START_TIMEOUT = 20000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          tx_enable,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    Tx_DATA,
    output logic          Tx_WR,
    output logic          TX_EN,
    input  logic          TX_BUSY,
    output logic          err_timeout
`ifdef UART_TXQ_OVF_CNT_EN
    ,
    output logic [15:0]   ovf_count
`endif
);

    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_n;
    logic          push;
    logic          commit;

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic [7:0]    tx_data_n;
    logic          tx_wr_n;
    logic          tx_en_n;
    logic          err_n;

    // Pushes are gated by the registered full flag, so a same-cycle pop
    // never makes room for a push arriving while full.
    assign push = wr_en && !full;

    // Next entry count from push/commit; both together leave it unchanged.
    always_comb begin
        level_n = level;
        if (push && !commit) begin
            level_n = level + LEVEL_ONE;
        end else if (!push && commit) begin
            level_n = level - LEVEL_ONE;
        end
    end

    // Storage array write; contents need no reset because level gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (commit) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level    <= level_n;
            full     <= (level_n == LEVEL_FULL);
            empty    <= (level_n == '0);
            overflow <= wr_en && full;
        end
    end

    // Sequencer state register with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            Tx_DATA     <= 8'h00;
            Tx_WR       <= 1'b0;
            TX_EN       <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            Tx_DATA     <= tx_data_n;
            Tx_WR       <= tx_wr_n;
            TX_EN       <= tx_en_n;
            err_timeout <= err_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        tx_data_n = Tx_DATA;
        tx_wr_n   = 1'b0;
        tx_en_n   = 1'b0;
        err_n     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && tx_enable) begin
                    state_n   = LOAD;
                    tx_data_n = mem[rd_ptr];
                    tx_wr_n   = 1'b1;
                    tx_en_n   = 1'b1;
                end
            end
            LOAD: begin
                state_n = WAIT_BUSY;
                timer_n = '0;
                tx_en_n = 1'b1;
            end
            WAIT_BUSY: begin
                tx_en_n = 1'b1;
                if (TX_BUSY) begin
                    commit  = 1'b1;
                    state_n = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    err_n   = 1'b1;
                    tx_en_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + TIMER_ONE;
                end
            end
            WAIT_DONE: begin
                tx_en_n = 1'b1;
                if (!TX_BUSY) begin
                    tx_en_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef UART_TXQ_OVF_CNT_EN
    // Saturating count of dropped pushes, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= 16'h0000;
        end else if (wr_en && full && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
// Directed bench for uart_tx_queue with a simple transmitter model that
// raises TX_BUSY a programmable number of cycles after Tx_WR and holds it.
// Define UART_TXQ_OVF_CNT_EN to also exercise ovf_count.

module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int T_ST  = 20000;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          tx_enable;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    Tx_DATA;
    logic          Tx_WR;
    logic          TX_EN;
    logic          TX_BUSY;
    logic          err_timeout;
`ifdef UART_TXQ_OVF_CNT_EN
    logic [15:0]   ovf_count;
`endif

    int vecs = 0;
    int errs = 0;

    // transmitter model state
    bit         model_on = 1'b1;
    int         busy_delay = 5;
    int         busy_hold = 40;
    int         ph = 0;
    int         cnt = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] rx [64];
    int         rx_n = 0;

    uart_tx_queue #(
        .DEPTH         (DEPTH),
        .AW            (AW),
        .START_TIMEOUT (T_ST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .tx_enable   (tx_enable),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .TX_EN       (TX_EN),
        .TX_BUSY     (TX_BUSY),
        .err_timeout (err_timeout)
`ifdef UART_TXQ_OVF_CNT_EN
        ,
        .ovf_count   (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter model: captures the byte on Tx_WR, raises TX_BUSY
    // busy_delay cycles later, drops it busy_hold cycles after that, and
    // checks that Tx_DATA and TX_EN stay put for the whole frame.
    initial begin
        TX_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                ph      = 0;
                TX_BUSY = 1'b0;
            end else begin
                if (ph != 0) begin
                    vecs++;
                    if (Tx_DATA !== cap || TX_EN !== 1'b1) begin
                        errs++;
                        $display("FAIL frame_hold: Tx_DATA=%h TX_EN=%b, required %h/1", Tx_DATA, TX_EN, cap);
                    end
                end
                if (ph == 0) begin
                    if (model_on && Tx_WR === 1'b1) begin
                        cap = Tx_DATA;
                        if (rx_n < 64) rx[rx_n] = Tx_DATA;
                        rx_n++;
                        cnt = busy_delay;
                        ph  = 1;
                    end
                end else if (ph == 1) begin
                    cnt--;
                    if (cnt == 0) begin
                        TX_BUSY = 1'b1;
                        cnt     = busy_hold;
                        ph      = 2;
                    end
                end else begin
                    cnt--;
                    if (cnt == 0) begin
                        TX_BUSY = 1'b0;
                        ph      = 0;
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (empty === 1'b1 && TX_EN === 1'b0 && ph == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (Tx_WR === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({empty, full, overflow, Tx_WR, TX_EN, err_timeout} !== 6'b100000) begin
            errs++;
            $display("FAIL reset_flags: e/f/ovf/wr/en/err=%b, required 100000",
                     {empty, full, overflow, Tx_WR, TX_EN, err_timeout});
        end
        vecs++;
        if (level !== 5'd0 || Tx_DATA !== 8'h00) begin
            errs++;
            $display("FAIL reset_values: level=%0d Tx_DATA=%h, required 0/00", level, Tx_DATA);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        bit ok;
        model_on = 1'b1; busy_delay = 5; busy_hold = 40; rx_n = 0;
        tx_enable = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        vecs++;
        if (level !== 5'd1 || Tx_WR !== 1'b0) begin
            errs++;
            $display("FAIL single_push: level=%0d Tx_WR=%b, required 1/0", level, Tx_WR);
        end
        @(negedge clk);
        vecs++;
        if (Tx_WR !== 1'b1 || TX_EN !== 1'b1 || Tx_DATA !== 8'hA5) begin
            errs++;
            $display("FAIL single_load: Tx_WR=%b TX_EN=%b Tx_DATA=%h, required 1/1/a5", Tx_WR, TX_EN, Tx_DATA);
        end
        @(negedge clk);
        vecs++;
        if (Tx_WR !== 1'b0) begin
            errs++;
            $display("FAIL single_wr_width: Tx_WR=%b, required 0", Tx_WR);
        end
        wait_drain(200, ok);
        vecs++;
        if (!ok || level !== 5'd0 || empty !== 1'b1) begin
            errs++;
            $display("FAIL single_drain: done=%0b level=%0d empty=%b, required 1/0/1", ok, level, empty);
        end
        vecs++;
        if (rx_n != 1 || rx[0] !== 8'hA5) begin
            errs++;
            $display("FAIL single_rx: count=%0d byte=%h, required 1/a5", rx_n, rx[0]);
        end
    endtask

    task automatic test_full_overflow();
        bit ok;
        tx_enable = 1'b0; busy_delay = 5; busy_hold = 40;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        vecs++;
        if (full !== 1'b1 || level !== 5'd16 || empty !== 1'b0 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL full_flags: full=%b level=%0d empty=%b ovf=%b, required 1/16/0/0", full, level, empty, overflow);
        end
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        vecs++;
        if (overflow !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
            errs++;
            $display("FAIL overflow_pulse: ovf=%b level=%0d full=%b, required 1/16/1", overflow, level, full);
        end
        @(negedge clk);
        vecs++;
        if (overflow !== 1'b0) begin
            errs++;
            $display("FAIL overflow_width: ovf=%b, required 0", overflow);
        end
        rx_n = 0;
        tx_enable = 1'b1;
        wait_drain(2000, ok);
        vecs++;
        if (!ok || rx_n != DEPTH) begin
            errs++;
            $display("FAIL full_drain: done=%0b frames=%0d, required 1/16", ok, rx_n);
        end
        for (int i = 0; i < DEPTH; i++) begin
            vecs++;
            if (rx[i] !== 8'(i)) begin
                errs++;
                $display("FAIL full_order[%0d]: byte=%h, required %h", i, rx[i], 8'(i));
            end
        end
    endtask

    task automatic test_push_commit();
        bit ok;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h31; exp_b[1] = 8'h32; exp_b[2] = 8'h33; exp_b[3] = 8'h34;
        tx_enable = 1'b0; busy_delay = 5; busy_hold = 20; rx_n = 0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp_b[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
        tx_enable = 1'b1;
        wait_wr(10, ok);
        vecs++;
        if (!ok || level !== 5'd3) begin
            errs++;
            $display("FAIL pc_load: seen=%0b level=%0d, required 1/3", ok, level);
        end
        // TX_BUSY rises on this negedge; push lands on the commit edge.
        repeat (5) @(negedge clk);
        wr_en = 1'b1; wr_data = exp_b[3];
        @(negedge clk);
        wr_en = 1'b0;
        vecs++;
        if (level !== 5'd3 || TX_EN !== 1'b1) begin
            errs++;
            $display("FAIL pc_level: level=%0d TX_EN=%b, required 3/1", level, TX_EN);
        end
        wait_drain(500, ok);
        vecs++;
        if (!ok || rx_n != 4) begin
            errs++;
            $display("FAIL pc_drain: done=%0b frames=%0d, required 1/4", ok, rx_n);
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (rx[i] !== exp_b[i]) begin
                errs++;
                $display("FAIL pc_order[%0d]: byte=%h, required %h", i, rx[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int waits;
        bit seen;
        tx_enable = 1'b0; model_on = 1'b0;
        wr_en = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 1'b0;
        tx_enable = 1'b1;
        wait_wr(10, ok);
        waits = 0; seen = 1'b0;
        for (int i = 0; i < T_ST + 100; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (TX_EN === 1'b1 && Tx_WR === 1'b0) waits++;
        end
        vecs++;
        if (!ok || !seen || waits != T_ST) begin
            errs++;
            $display("FAIL timeout_len: load=%0b err=%0b wait_cycles=%0d, required 1/1/%0d", ok, seen, waits, T_ST);
        end
        vecs++;
        if (level !== 5'd1 || TX_EN !== 1'b0) begin
            errs++;
            $display("FAIL timeout_keep: level=%0d TX_EN=%b, required 1/0", level, TX_EN);
        end
        model_on = 1'b1; busy_delay = 3; busy_hold = 10; rx_n = 0;
        @(negedge clk);
        vecs++;
        if (err_timeout !== 1'b0 || Tx_WR !== 1'b1 || Tx_DATA !== 8'h5A) begin
            errs++;
            $display("FAIL timeout_retry: err=%b Tx_WR=%b Tx_DATA=%h, required 0/1/5a", err_timeout, Tx_WR, Tx_DATA);
        end
        wait_drain(200, ok);
        vecs++;
        if (!ok || rx_n != 1 || rx[0] !== 8'h5A || level !== 5'd0) begin
            errs++;
            $display("FAIL timeout_drain: done=%0b frames=%0d byte=%h level=%0d, required 1/1/5a/0", ok, rx_n, rx[0], level);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        tx_enable = 1'b0; model_on = 1'b1; busy_delay = 2; busy_hold = 40;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        tx_enable = 1'b1;
        wait_wr(10, ok);
        repeat (5) @(negedge clk);
        vecs++;
        if (!ok || level !== 5'd4 || TX_EN !== 1'b1) begin
            errs++;
            $display("FAIL mid_pre: load=%0b level=%0d TX_EN=%b, required 1/4/1", ok, level, TX_EN);
        end
        reset = 1'b1;
        #1;
        vecs++;
        if ({empty, full, overflow, Tx_WR, TX_EN, err_timeout} !== 6'b100000
            || level !== 5'd0 || Tx_DATA !== 8'h00) begin
            errs++;
            $display("FAIL mid_reset: e/f/ovf/wr/en/err=%b level=%0d Tx_DATA=%h, required 100000/0/00",
                     {empty, full, overflow, Tx_WR, TX_EN, err_timeout}, level, Tx_DATA);
        end
        tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if (level !== 5'd0 || TX_EN !== 1'b0 || empty !== 1'b1) begin
            errs++;
            $display("FAIL mid_after: level=%0d TX_EN=%b empty=%b, required 0/0/1", level, TX_EN, empty);
        end
    endtask

`ifdef UART_TXQ_OVF_CNT_EN
    task automatic test_ovf_count();
        tx_enable = 1'b0;
        vecs++;
        if (ovf_count !== 16'd0) begin
            errs++;
            $display("FAIL ovf_cnt_reset: ovf_count=%0d, required 0", ovf_count);
        end
        for (int i = 0; i < DEPTH + 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
        vecs++;
        if (ovf_count !== 16'd3 || level !== 5'd16) begin
            errs++;
            $display("FAIL ovf_cnt: ovf_count=%0d level=%0d, required 3/16", ovf_count, level);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_full_overflow();
        test_push_commit();
        test_timeout();
        test_reset_mid_frame();
`ifdef UART_TXQ_OVF_CNT_EN
        test_ovf_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
